// File: rtl/dbnc_pkg.sv
// Shared types and default constants for the synchronizing debouncer.
// Optional feature macro used by sync_debounce: DBNC_GLITCH_CNT_EN.
package dbnc_pkg;

  localparam int unsigned DBNC_SYNC_STAGES_DEF = 2;
  localparam int unsigned DBNC_CYCLES_DEF      = 16;

  typedef enum logic [0:0] {
    ST_STABLE = 1'b0,
    ST_QUAL   = 1'b1
  } dbnc_state_t;

endpackage

// File: rtl/sync_chain.sv
// Plain N-flop synchronizer with a synchronous, active-high reset.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset, loads RST_VAL into every flop
//   async_i in  raw asynchronous input
//   sync_o  out synchronized level (last flop of the chain)
module sync_chain
  import dbnc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DBNC_SYNC_STAGES_DEF,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] s_q;

  // Flop-to-flop only; nothing may sit between stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      s_q <= {s_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_o = s_q[SYNC_STAGES-1];

endmodule

// File: rtl/sync_debounce.sv
// Synchronizes a raw asynchronous input and only lets a new level through
// once it has been seen for DBNC_CYCLES consecutive cycles. Feeds the
// edge detector's sig input.
// Optional feature: define DBNC_GLITCH_CNT_EN to add a saturating count of
// rejected glitches (glitch_cnt, GLITCH_W bits).
// Ports:
//   clk        in  clock
//   rst        in  synchronous active-high reset
//   async_in   in  raw asynchronous input
//   sig_out    out debounced synchronous level
//   stable     out high while no qualification is in progress
//   glitch_cnt out saturating rejected-glitch count (DBNC_GLITCH_CNT_EN only)
module sync_debounce
  import dbnc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DBNC_SYNC_STAGES_DEF,
  parameter int unsigned DBNC_CYCLES = DBNC_CYCLES_DEF,
  parameter logic        RST_VAL     = 1'b0
`ifdef DBNC_GLITCH_CNT_EN
  ,
  parameter int unsigned GLITCH_W    = 8
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                async_in,
  output logic                sig_out,
  output logic                stable
`ifdef DBNC_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DBNC_CYCLES + 1);

  logic              sync_q;
  dbnc_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sig_q, sig_d;
`ifdef DBNC_GLITCH_CNT_EN
  logic              abort_c;
  logic [GLITCH_W-1:0] glitch_q;
`endif

  sync_chain #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (RST_VAL)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (async_in),
    .sync_o  (sync_q)
  );

  // State, qualification count and debounced level.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      sig_q   <= RST_VAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
    end
  end

  // Next state: count consecutive disagreeing cycles, abort on agreement.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
`ifdef DBNC_GLITCH_CNT_EN
    abort_c = 1'b0;
`endif
    unique case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (sync_q != sig_q) begin
          // A one-cycle qualification needs no counting state.
          if (DBNC_CYCLES == 1) begin
            sig_d = sync_q;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = ST_QUAL;
          end
        end
      end
      ST_QUAL: begin
        if (sync_q == sig_q) begin
          cnt_d   = '0;
          state_d = ST_STABLE;
`ifdef DBNC_GLITCH_CNT_EN
          abort_c = 1'b1;
`endif
        end else if (cnt_q == CNT_W'(DBNC_CYCLES - 1)) begin
          sig_d   = sync_q;
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_STABLE;
      end
    endcase
  end

`ifdef DBNC_GLITCH_CNT_EN
  // Saturating count of aborted qualifications.
  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_q <= '0;
    end else if (abort_c && (glitch_q != {GLITCH_W{1'b1}})) begin
      glitch_q <= glitch_q + GLITCH_W'(1);
    end
  end

  assign glitch_cnt = glitch_q;
`endif

  assign sig_out = sig_q;
  assign stable  = (state_q == ST_STABLE);

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: three instances (DBNC_CYCLES 16, 1 and 4) checked
// every cycle against a run-length model, plus hand-computed checkpoints.
module tb_sync_debounce;

  logic clk = 1'b0;
  logic rst;
  logic a0, a1, a4;
  logic so0, st0, so1, st1, so4, st4;
`ifdef DBNC_GLITCH_CNT_EN
  logic [7:0] g0, g1;
  logic [1:0] g4;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sync_debounce #(.SYNC_STAGES(2), .DBNC_CYCLES(16), .RST_VAL(1'b0)
`ifdef DBNC_GLITCH_CNT_EN
    , .GLITCH_W(8)
`endif
  ) u_d16 (.clk(clk), .rst(rst), .async_in(a0), .sig_out(so0), .stable(st0)
`ifdef DBNC_GLITCH_CNT_EN
    , .glitch_cnt(g0)
`endif
  );

  sync_debounce #(.SYNC_STAGES(2), .DBNC_CYCLES(1), .RST_VAL(1'b0)
`ifdef DBNC_GLITCH_CNT_EN
    , .GLITCH_W(8)
`endif
  ) u_d1 (.clk(clk), .rst(rst), .async_in(a1), .sig_out(so1), .stable(st1)
`ifdef DBNC_GLITCH_CNT_EN
    , .glitch_cnt(g1)
`endif
  );

  sync_debounce #(.SYNC_STAGES(2), .DBNC_CYCLES(4), .RST_VAL(1'b0)
`ifdef DBNC_GLITCH_CNT_EN
    , .GLITCH_W(2)
`endif
  ) u_d4 (.clk(clk), .rst(rst), .async_in(a4), .sig_out(so4), .stable(st4)
`ifdef DBNC_GLITCH_CNT_EN
    , .glitch_cnt(g4)
`endif
  );

  // Model: the synchronizer is a plain delay line; the output flips once the
  // delayed input has disagreed with it for D consecutive cycles.
  int unsigned S_P  [3] = '{2, 2, 2};
  int unsigned D_P  [3] = '{16, 1, 4};
  int unsigned GMAX [3] = '{255, 255, 3};
  logic        pipe [3][8];
  logic        m_out [3];
  int unsigned m_run [3];
  int unsigned m_gl  [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input logic in);
    logic x;
    if (rst) begin
      for (int k = 0; k < 8; k++) pipe[i][k] = 1'b0;
      m_out[i] = 1'b0;
      m_run[i] = 0;
      m_gl[i]  = 0;
      return;
    end
    x = pipe[i][S_P[i]-1];
    for (int k = 7; k > 0; k--) pipe[i][k] = pipe[i][k-1];
    pipe[i][0] = in;
    if (x != m_out[i]) begin
      m_run[i]++;
      if (m_run[i] >= D_P[i]) begin
        m_out[i] = x;
        m_run[i] = 0;
      end
    end else begin
      if (m_run[i] > 0 && m_gl[i] < GMAX[i]) m_gl[i]++;
      m_run[i] = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step(0, a0);
    model_step(1, a1);
    model_step(2, a4);
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("d16 sig_out", 32'(so0), 32'(m_out[0]));
    chk("d16 stable",  32'(st0), 32'(m_run[0] == 0));
    chk("d1 sig_out",  32'(so1), 32'(m_out[1]));
    chk("d1 stable",   32'(st1), 32'(m_run[1] == 0));
    chk("d4 sig_out",  32'(so4), 32'(m_out[2]));
    chk("d4 stable",   32'(st4), 32'(m_run[2] == 0));
`ifdef DBNC_GLITCH_CNT_EN
    chk("d16 glitch_cnt", 32'(g0), m_gl[0]);
    chk("d1 glitch_cnt",  32'(g1), m_gl[1]);
    chk("d4 glitch_cnt",  32'(g4), m_gl[2]);
`endif
  end

  // Edges until so0 rises (0 = never within budget) and stable-low samples.
  task automatic count_rise(output int edge_n, output int low_n);
    edge_n = 0;
    low_n  = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (!st0) low_n++;
      if (so0) begin
        edge_n = n;
        break;
      end
    end
  endtask

  initial begin
    int e, l, hi;
    logic [7:0] v;
    rst = 1'b1; a0 = 1'b1; a1 = 1'b0; a4 = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chk("reset sig_out", 32'(so0), 32'd0);
      chk("reset stable",  32'(st0), 32'd1);
`ifdef DBNC_GLITCH_CNT_EN
      chk("reset glitch_cnt", 32'(g0), 32'd0);
`endif
    end
    rst = 1'b0; a0 = 1'b0;
    repeat (4) @(negedge clk);

    // Clean rise
    a0 = 1'b1;
    count_rise(e, l);
    chk("clean rise edge", e, 32'd18);
    chk("clean rise stable-low cycles", l, 32'd15);
    repeat (5) @(negedge clk);
    chk("held high", 32'(so0), 32'd1);
    a0 = 1'b0;
    repeat (25) @(negedge clk);
    chk("clean fall", 32'(so0), 32'd0);

    // Single 10-cycle glitch
    a0 = 1'b1;
    repeat (10) @(negedge clk);
    a0 = 1'b0;
    hi = 0;
    repeat (25) begin
      @(negedge clk);
      if (so0) hi++;
    end
    chk("glitch sig_out high cycles", hi, 32'd0);
    chk("glitch stable after", 32'(st0), 32'd1);
`ifdef DBNC_GLITCH_CNT_EN
    chk("glitch count", 32'(g0), 32'd1);
`endif

    // Bounce: 4 bursts, then held high
    repeat (4) begin
      a0 = 1'b1;
      repeat (3) @(negedge clk);
      a0 = 1'b0;
      repeat (2) @(negedge clk);
    end
    a0 = 1'b1;
    count_rise(e, l);
    chk("bounce rise edge", e, 32'd18);
`ifdef DBNC_GLITCH_CNT_EN
    chk("bounce glitch count (1 prior + 4)", 32'(g0), 32'd5);
`endif

    // Reset in the middle of a qualification
    @(negedge clk);
    a0 = 1'b0;
    repeat (25) @(negedge clk);
    chk("pre mid-reset low", 32'(so0), 32'd0);
    a0 = 1'b1;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid-reset sig_out", 32'(so0), 32'd0);
    chk("mid-reset stable",  32'(st0), 32'd1);
`ifdef DBNC_GLITCH_CNT_EN
    chk("mid-reset glitch_cnt", 32'(g0), 32'd0);
`endif
    count_rise(e, l);
    chk("post-reset rise edge", e, 32'd18);

    // DBNC_CYCLES=1: single-cycle pulse passes, delayed 3 edges
    @(negedge clk);
    a1 = 1'b1;
    v = '0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1;
      v[n-1] = so1;
      if (n == 1) begin
        @(negedge clk);
        a1 = 1'b0;
      end
    end
    chk("d1 pulse profile", 32'(v), 32'h04);

    // DBNC_CYCLES=4: exactly-4 pulse passes, 3-cycle pulse is rejected
    @(negedge clk);
    a4 = 1'b1;
    repeat (4) @(negedge clk);
    a4 = 1'b0;
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (so4) hi++;
    end
    chk("d4 exact pulse high cycles", hi, 32'd4);
    a4 = 1'b1;
    repeat (3) @(negedge clk);
    a4 = 1'b0;
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (so4) hi++;
    end
    chk("d4 short pulse high cycles", hi, 32'd0);

    // Forced aborts saturate the 2-bit counter
    repeat (5) begin
      a4 = 1'b1;
      repeat (2) @(negedge clk);
      a4 = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("d4 sig_out after aborts", 32'(so4), 32'd0);
`ifdef DBNC_GLITCH_CNT_EN
    chk("d4 glitch_cnt saturated", 32'(g4), 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sync_debounce.md
Name: sync_debounce

Overview:
Conditions a raw asynchronous input, such as a pushbutton, switch or external strobe, into a clean, clock-synchronous level. Sits directly upstream of the edge-detector stage: sig_out drives that stage's sig input.
- An N-flop synchronizer removes metastability.
- A qualification counter FSM rejects bounces and glitches shorter than DBNC_CYCLES cycles.

Parameters:
- SYNC_STAGES, 2: synchronizer flop count; must be >= 2.
- DBNC_CYCLES, 16: consecutive cycles the synchronized input must differ from sig_out before sig_out follows it; must be >= 1.
- RST_VAL, 1'b0: reset value of the synchronizer chain and of sig_out.
- GLITCH_W, 8: width of the glitch counter (optional feature only).
- Localparam CNT_W = $clog2(DBNC_CYCLES+1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- async_in  in  1  raw asynchronous input.
- sig_out  out  1  debounced synchronous level; feeds the edge detector.
- stable  out  1  high when the FSM is in ST_STABLE, i.e. no qualification is in progress.
- glitch_cnt  out  GLITCH_W  saturating count of rejected glitches; present only with DBNC_GLITCH_CNT_EN.

Behaviour:
- Reset (rst=1 at posedge):
  - all synchronizer flops <= RST_VAL;
  - sig_out <= RST_VAL, cnt <= 0, state <= ST_STABLE, stable = 1;
  - glitch_cnt <= 0.
  - rst overrides everything, including mid-qualification; any partial count is discarded.
- Synchronizer:
  - s[0] <= async_in; s[i] <= s[i-1]; sync_q = s[SYNC_STAGES-1].
  - No logic is permitted between the synchronizer flops.
- FSM states: ST_STABLE, ST_QUAL.
  - ST_STABLE, sync_q == sig_out: hold, cnt = 0.
  - ST_STABLE, sync_q != sig_out:
    - if DBNC_CYCLES == 1: sig_out <= sync_q and stay in ST_STABLE;
    - else: cnt <= 1 and go to ST_QUAL.
  - ST_QUAL, sync_q == sig_out: glitch rejected; cnt <= 0, go to ST_STABLE, glitch_cnt += 1 (saturating).
  - ST_QUAL, sync_q != sig_out, cnt == DBNC_CYCLES-1: sig_out <= sync_q, cnt <= 0, go to ST_STABLE.
  - ST_QUAL, sync_q != sig_out, otherwise: cnt <= cnt + 1.
- Latency:
  - async_in changes before edge 1 and is held; sig_out updates at edge SYNC_STAGES + DBNC_CYCLES.
  - Defaults: 18 edges.
- Pulse rejection:
  - any async_in pulse shorter than DBNC_CYCLES cycles never reaches sig_out;
  - a pulse of exactly DBNC_CYCLES cycles does pass.
- sig_out changes at most once per DBNC_CYCLES cycles. The downstream edge detector therefore sees at most one edge per qualified transition.
- cnt never exceeds DBNC_CYCLES-1; no wrap-around is possible.
- After rst deasserts with async_in != RST_VAL, the chain refills. sig_out then changes SYNC_STAGES + DBNC_CYCLES edges later, same as a normal transition.
- All outputs are registered except stable, which is decoded from the state register.

Optional Feature:
- Macro: DBNC_GLITCH_CNT_EN.
- Defined:
  - glitch_cnt port and register exist;
  - increments on every ST_QUAL to ST_STABLE abort;
  - saturates at 2^GLITCH_W - 1;
  - cleared only by rst.
- Undefined: port and register are absent; FSM behaviour is identical.

Decomposition:
- Package dbnc_pkg holds:
  - state enum typedef dbnc_state_t {ST_STABLE, ST_QUAL};
  - default constants DBNC_SYNC_STAGES_DEF = 2 and DBNC_CYCLES_DEF = 16.
- One sub-module, sync_chain: a parameterised SYNC_STAGES flop synchronizer with RST_VAL and synchronous reset, reusable elsewhere.

Test Plan:
- Reset: async_in=1 held, rst=1 for 3 cycles -> sig_out=0, stable=1, glitch_cnt=0 throughout reset.
- Clean rise (defaults): async_in 0->1 held after reset -> sig_out rises exactly 18 edges later, stays 1; stable low for 15 cycles before the rise.
- Single glitch: async_in high for 10 cycles then low -> sig_out stays 0; glitch_cnt=1; stable returns to 1.
- Bounce: 4 bursts of 3 cycles high / 2 cycles low, then held high -> glitch_cnt=4; sig_out rises 18 edges after the final 0->1 transition.
- Reset mid-qualify: async_in 0->1, rst pulsed 1 cycle at edge 12 -> sig_out=0 and state ST_STABLE after that edge. sig_out rises 18 edges after rst deassertion.
- Boundary instance DBNC_CYCLES=1:
  - a 1-cycle high pulse appears on sig_out for exactly 1 cycle, 3 edges later;
  - with GLITCH_W=2, forced aborts on a DBNC_CYCLES=4 instance saturate glitch_cnt at 3.
